uart_rom_loader: RTL and testbench

//  Sits between the UART byte receiver and the instruction ROM write port of sm_top.

---
 rtl/uart_rom_loader.sv | 136 +++++++++++++
 tb/tb_uart_rom_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rom_loader.sv
// Packs UART bytes MSB-first into 32-bit words and writes them to consecutive ROM addresses.
// Tracks busy/done status and a sticky inter-byte timeout flag per load session.
module uart_rom_loader #(
  parameter int ADDR_WIDTH   = 5,
  parameter int WORDS        = 16,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [31:0]           rom_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  frame_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int CW = ADDR_WIDTH + 1;
  localparam int GW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] WORDS_LAST   = CW'(WORDS - 1);
  localparam logic [GW-1:0] TIMEOUT_LAST = GW'(TIMEOUT_CLKS - 1);

  logic [1:0]            state_q, state_d;
  logic [31:0]           shreg_q, shreg_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [CW-1:0]         word_count_q, word_count_d;
  logic [31:0]           rom_wdata_q, rom_wdata_d;
  logic                  done_q, done_d;
  logic                  frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    byte_idx_d   = byte_idx_q;
    gap_d        = gap_q;
    rom_addr_d   = rom_addr_q;
    word_count_d = word_count_q;
    rom_wdata_d  = rom_wdata_q;
    done_d       = done_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      S_COLLECT: begin
        if (rx_valid) begin
          shreg_d    = {shreg_q[23:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          gap_d      = '0;
          if (byte_idx_q == 2'd3) begin
            rom_wdata_d = {shreg_q[23:0], rx_data};
            state_d     = S_WRITE;
          end
        end else if (byte_idx_q != 2'd0) begin
          // A stalled partial word is dropped so the host can resync on word boundaries.
          if (gap_q == TIMEOUT_LAST) begin
            byte_idx_d  = 2'd0;
            gap_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        rom_addr_d   = rom_addr_q + 1'b1;
        word_count_d = word_count_q + 1'b1;
        if (word_count_q == WORDS_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_COLLECT;
          // shreg is separate from rom_wdata, so a byte here starts the next word.
          if (rx_valid) begin
            shreg_d    = {shreg_q[23:0], rx_data};
            byte_idx_d = 2'd1;
          end
        end
      end
      default: ;
    endcase

    // Restart wins over everything; a write already on the bus this cycle still lands.
    if (load_start) begin
      state_d      = S_COLLECT;
      byte_idx_d   = 2'd0;
      gap_d        = '0;
      rom_addr_d   = '0;
      word_count_d = '0;
      done_d       = 1'b0;
      frame_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      byte_idx_q   <= 2'd0;
      gap_q        <= '0;
      rom_addr_q   <= '0;
      word_count_q <= '0;
      rom_wdata_q  <= '0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      byte_idx_q   <= byte_idx_d;
      gap_q        <= gap_d;
      rom_addr_q   <= rom_addr_d;
      word_count_q <= word_count_d;
      rom_wdata_q  <= rom_wdata_d;
      done_q       <= done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rom_we     = (state_q == S_WRITE);
  assign busy       = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign done       = done_q;
  assign rom_addr   = rom_addr_q;
  assign rom_wdata  = rom_wdata_q;
  assign word_count = word_count_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader: a session-level byte/word model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_uart_rom_loader;

  localparam int AW    = 5;
  localparam int WORDS = 16;
  localparam int TO    = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_wdata;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;
  logic          frame_err;

  uart_rom_loader #(.ADDR_WIDTH(AW), .WORDS(WORDS), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata), .busy(busy), .done(done),
    .word_count(word_count), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Session model: bytes accumulate in a queue; a full queue becomes a pending write.
  bit         m_started = 0;
  bit         m_active, m_done, m_pending, m_frame;
  int         m_addr, m_count, m_gap;
  logic [31:0] m_word;
  logic [7:0] m_part[$];

  always @(posedge clk) begin
    if (rst) begin
      m_started = 1; m_active = 0; m_done = 0; m_pending = 0; m_frame = 0;
      m_addr = 0; m_count = 0; m_gap = 0; m_word = '0; m_part.delete();
    end else if (m_started) begin
      if (m_pending) begin
        m_pending = 0;
        m_addr = (m_addr + 1) % (1 << AW);
        m_count++;
        if (m_count == WORDS) begin m_done = 1; m_active = 0; end
      end
      if (load_start) begin
        m_active = 1; m_done = 0; m_frame = 0; m_addr = 0; m_count = 0; m_gap = 0;
        m_part.delete();
      end else if (m_active) begin
        if (rx_valid) begin
          m_part.push_back(rx_data);
          m_gap = 0;
          if (m_part.size() == 4) begin
            m_word = {m_part[0], m_part[1], m_part[2], m_part[3]};
            m_part.delete();
            m_pending = 1;
          end
        end else if (m_part.size() != 0) begin
          m_gap++;
          if (m_gap == TO) begin m_part.delete(); m_gap = 0; m_frame = 1; end
        end
      end
    end
  end

  logic [31:0] wlog [0:(1<<AW)-1];
  int          nwrites = 0;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;

  always @(negedge clk) begin
    if (m_started) begin
      check("rom_we", rom_we, m_pending);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("word_count", word_count, m_count);
      check("frame_err", frame_err, m_frame);
      check("rom_addr", rom_addr, m_addr);
      if (m_pending) check("rom_wdata", rom_wdata, m_word);
      if (rom_we === 1'b1) begin
        wlog[rom_addr] = rom_wdata;
        last_addr = rom_addr;
        last_data = rom_wdata;
        nwrites++;
        $display("write addr=%0d data=%08h", rom_addr, rom_wdata);
      end
    end
  end

  task automatic drive(input bit ls, input bit v, input logic [7:0] d);
    load_start = ls; rx_valid = v; rx_data = d;
    @(posedge clk); #1;
    load_start = 0; rx_valid = 0;
  endtask

  task automatic send(input logic [7:0] b); drive(0, 1, b); endtask
  task automatic idle(input int n); repeat (n) drive(0, 0, 8'h00); endtask
  task automatic start(); drive(1, 0, 8'h00); endtask

  int base;

  initial begin
    rst = 1; load_start = 0; rx_valid = 0; rx_data = 8'h00;
    repeat (3) begin @(posedge clk); #1; end
    rst = 0;
    check("reset_rom_we", rom_we, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_word_count", word_count, 0);
    check("reset_rom_wdata", rom_wdata, 0);
    check("reset_frame_err", frame_err, 0);

    // 1: single word
    start();
    check("busy_after_start", busy, 1);
    send(8'h00); send(8'h10); send(8'h00); send(8'h73);
    check("latency_rom_we", rom_we, 1);
    idle(2);
    check("t1_nwrites", nwrites, 1);
    check("t1_addr", last_addr, 0);
    check("t1_data", last_data, 32'h00100073);
    check("t1_count", word_count, 1);

    // 2 and 4: full session back-to-back, bytes land in WRITE cycles
    start();
    base = nwrites;
    for (int i = 0; i < 64; i++) send(8'(i));
    idle(3);
    check("t2_nwrites", nwrites - base, 16);
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    check("t2_count", word_count, 16);
    check("t2_rom_addr", rom_addr, 16);
    check("t4_word1", wlog[1], 32'h04050607);
    check("t2_word15", wlog[15], 32'h3c3d3e3f);
    send(8'h99); idle(3);
    check("t2_extra_byte", nwrites - base, 16);

    // 3: timeout drops partial word; one cycle short does not
    start();
    send(8'h12); send(8'h34); idle(TO);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); idle(2);
    check("t3_frame_err", frame_err, 1);
    check("t3_addr", last_addr, 0);
    check("t3_data", last_data, 32'hAABBCCDD);
    check("t3_count", word_count, 1);
    send(8'h01); send(8'h02); idle(TO - 1); send(8'h03); send(8'h04); idle(2);
    check("t3_edge_addr", last_addr, 1);
    check("t3_edge_data", last_data, 32'h01020304);

    // 5: reset mid-word
    start();
    for (int i = 0; i < 10; i++) send(8'(8'h20 + i));
    base = nwrites;
    rst = 1; drive(0, 0, 8'h00); rst = 0;
    check("t5_busy", busy, 0);
    check("t5_count", word_count, 0);
    check("t5_addr", rom_addr, 0);
    check("t5_wdata", rom_wdata, 0);
    idle(3);
    check("t5_no_write", nwrites - base, 0);
    start();
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); idle(2);
    check("t5_addr0", last_addr, 0);
    check("t5_data", last_data, 32'hDEADBEEF);

    // 6: restart mid-session, coinciding with a WRITE cycle and a byte
    start();
    send(8'h55); idle(TO);
    for (int i = 0; i < 20; i++) send(8'(8'h40 + i));
    idle(2);
    check("t6_count5", word_count, 5);
    check("t6_frame_set", frame_err, 1);
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    drive(1, 1, 8'h77);
    check("t6_write_completed", last_addr, 5);
    check("t6_count0", word_count, 0);
    check("t6_addr0", rom_addr, 0);
    check("t6_done0", done, 0);
    check("t6_frame_clr", frame_err, 0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); idle(2);
    check("t6_restart_addr", last_addr, 0);
    check("t6_restart_data", last_data, 32'h01020304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
